// File: rtl/serial_shift_unit.sv
// serial_shift_unit: bit-serial SLL/SRL/SRA for the 64-bit execute stage.
// Word mode shifts bits [31:0] and sign-extends the 32-bit result.
module serial_shift_unit #(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic               word,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    typedef enum logic [1:0] {
        s_idle,
        s_shift,
        s_done
    } state_t;

    localparam logic [1:0] op_sll  = 2'b00;
    localparam logic [1:0] op_srl  = 2'b01;
    localparam logic [1:0] op_sra  = 2'b10;
    localparam logic [1:0] op_pass = 2'b11;

    state_t             state, state_d;
    logic [SHAMT_W-1:0] cnt, cnt_d, eff;
    logic [WIDTH-1:0]   work, work_d, shifted, final_val, result_d;
    logic [1:0]         op_q, op_d;
    logic               word_q, word_d;
    logic [31:0]        lo;

    assign lo = work[31:0];

    always_comb begin
        if (op == op_pass)
            eff = '0;
        else if (word)
            eff = {{(SHAMT_W-5){1'b0}}, shamt[4:0]};
        else
            eff = shamt;
    end

    // Word mode keeps the upper half at zero; sign extension happens on completion.
    always_comb begin
        shifted = work;
        unique case (op_q)
            op_sll:  shifted = word_q ? {{(WIDTH-32){1'b0}}, lo[30:0], 1'b0}
                                      : {work[WIDTH-2:0], 1'b0};
            op_srl:  shifted = word_q ? {{(WIDTH-32){1'b0}}, 1'b0, lo[31:1]}
                                      : {1'b0, work[WIDTH-1:1]};
            op_sra:  shifted = word_q ? {{(WIDTH-32){1'b0}}, lo[31], lo[31:1]}
                                      : {work[WIDTH-1], work[WIDTH-1:1]};
            default: shifted = work;
        endcase
    end

    assign final_val = word_q ? {{(WIDTH-32){lo[31]}}, lo} : work;

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        work_d   = work;
        op_d     = op_q;
        word_d   = word_q;
        result_d = result;
        unique case (state)
            s_idle: begin
                if (start) begin
                    state_d = s_shift;
                    op_d    = op;
                    word_d  = word;
                    cnt_d   = eff;
                    work_d  = word ? {{(WIDTH-32){1'b0}}, operand[31:0]}
                                   : operand;
                end
            end
            s_shift: begin
                if (cnt == '0) begin
                    result_d = final_val;
                    state_d  = s_done;
                end else begin
                    work_d = shifted;
                    cnt_d  = cnt - {{(SHAMT_W-1){1'b0}}, 1'b1};
                end
            end
            s_done:  state_d = s_idle;
            default: state_d = s_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= s_idle;
            cnt    <= '0;
            work   <= '0;
            op_q   <= op_sll;
            word_q <= 1'b0;
            result <= '0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            work   <= work_d;
            op_q   <= op_d;
            word_q <= word_d;
            result <= result_d;
        end
    end

    assign busy = (state != s_idle);
    assign done = (state == s_done);

endmodule

// File: tb/tb_serial_shift_unit.sv
// tb_serial_shift_unit: directed checks of the bit-serial shifter.
// Inputs change and outputs are sampled on the falling edge.
module tb_serial_shift_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic        word;
    logic [63:0] operand;
    logic [5:0]  shamt;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int nvec = 0;
    int nerr = 0;

    serial_shift_unit #(.WIDTH(64), .SHAMT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .word(word),
        .operand(operand), .shamt(shamt), .busy(busy), .done(done),
        .result(result)
    );

    always #5 clk = ~clk;

    // Issue one request from a falling edge; returns the cycle index of done
    // (0 = cycle right after the accepting edge) and busy cycles before it.
    // Inputs are scrambled after acceptance to show they are not re-sampled.
    task automatic run_op(input logic [1:0] o, input logic w,
                          input logic [63:0] a, input logic [5:0] s,
                          output int lat, output int bcyc);
        op = o; word = w; operand = a; shamt = s; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op = ~o; word = ~w; operand = ~a; shamt = ~s;
        lat = -1; bcyc = 0;
        for (int k = 0; k < 200; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (busy) bcyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = 2'b00; word = 1'b0;
        operand = 64'h0; shamt = 6'd0;
        repeat (3) @(negedge clk);
        nvec++;
        if ({busy, done, result} !== 66'h0) begin
            nerr++;
            $display("FAIL reset_outputs: got busy=%b done=%b result=%h, want 0 0 0",
                     busy, done, result);
        end
        rst_n = 1'b1;
        @(negedge clk);
        nvec++;
        if ({busy, done} !== 2'b00) begin
            nerr++;
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_case(input string name, input logic [1:0] o,
                             input logic w, input logic [63:0] a,
                             input logic [5:0] s, input logic [63:0] exp_r,
                             input int exp_lat);
        int lat, bcyc;
        run_op(o, w, a, s, lat, bcyc);
        nvec++;
        if (lat !== exp_lat) begin
            nerr++;
            $display("FAIL %s_latency: got %0d, want %0d", name, lat, exp_lat);
        end
        nvec++;
        if (result !== exp_r) begin
            nerr++;
            $display("FAIL %s_result: got %h, want %h", name, result, exp_r);
        end
        nvec++;
        if (bcyc !== exp_lat) begin
            nerr++;
            $display("FAIL %s_busy_cycles: got %0d, want %0d", name, bcyc, exp_lat);
        end
        @(negedge clk);
        nvec++;
        if ({busy, done, result} !== {2'b00, exp_r}) begin
            nerr++;
            $display("FAIL %s_after: got busy=%b done=%b result=%h, want 0 0 %h",
                     name, busy, done, result, exp_r);
        end
    endtask

    task automatic test_shifts();
        test_case("sll63", 2'b00, 1'b0, 64'h1, 6'd63, 64'h8000_0000_0000_0000, 64);
        test_case("sra4", 2'b10, 1'b0, 64'h8000_0000_0000_0000, 6'd4,
                  64'hF800_0000_0000_0000, 5);
        test_case("srl4", 2'b01, 1'b0, 64'h8000_0000_0000_0000, 6'd4,
                  64'h0800_0000_0000_0000, 5);
    endtask

    task automatic test_word();
        test_case("w_sll1", 2'b00, 1'b1, 64'h1234_5678_4000_0001, 6'd1,
                  64'hFFFF_FFFF_8000_0002, 2);
        test_case("w_srl33", 2'b01, 1'b1, 64'hFFFF_FFFF_8000_0000, 6'd33,
                  64'h0000_0000_4000_0000, 2);
        test_case("w_sra4", 2'b10, 1'b1, 64'h0000_0000_8000_0000, 6'd4,
                  64'hFFFF_FFFF_F800_0000, 5);
    endtask

    task automatic test_zero_len();
        test_case("shamt0", 2'b01, 1'b0, 64'hDEAD_BEEF_0123_4567, 6'd0,
                  64'hDEAD_BEEF_0123_4567, 1);
        test_case("pass40", 2'b11, 1'b0, 64'h8765_4321_1234_5678, 6'd40,
                  64'h8765_4321_1234_5678, 1);
        test_case("w_pass", 2'b11, 1'b1, 64'h0000_1111_8000_0001, 6'd7,
                  64'hFFFF_FFFF_8000_0001, 1);
    endtask

    task automatic test_ignored_start();
        int ndone = 0;
        int first = -1;
        op = 2'b00; word = 1'b0; operand = 64'h3; shamt = 6'd10; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 30; k++) begin
            start = (k == 1) || (k == 11);
            operand = 64'hFF; shamt = 6'd1; op = 2'b01;
            if (done) begin
                ndone++;
                if (first < 0) first = k;
            end
            @(negedge clk);
        end
        start = 1'b0;
        nvec++;
        if (ndone !== 1) begin
            nerr++;
            $display("FAIL ign_done_count: got %0d, want 1", ndone);
        end
        nvec++;
        if (first !== 11) begin
            nerr++;
            $display("FAIL ign_latency: got %0d, want 11", first);
        end
        nvec++;
        if ({busy, result} !== {1'b0, 64'hC00}) begin
            nerr++;
            $display("FAIL ign_result: got busy=%b result=%h, want 0 c00",
                     busy, result);
        end
    endtask

    task automatic test_reset_abort();
        op = 2'b00; word = 1'b0; operand = 64'h1; shamt = 6'd20; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        nvec++;
        if ({busy, done, result} !== 66'h0) begin
            nerr++;
            $display("FAIL abort_async: got busy=%b done=%b result=%h, want 0 0 0",
                     busy, done, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_case("post_rst", 2'b01, 1'b0, 64'h10, 6'd2, 64'h4, 3);
    endtask

    task automatic test_back_to_back();
        int lat, bcyc;
        run_op(2'b00, 1'b0, 64'h5, 6'd3, lat, bcyc);
        nvec++;
        if (result !== 64'h28) begin
            nerr++;
            $display("FAIL b2b_first: got %h, want 28", result);
        end
        @(negedge clk);
        op = 2'b01; word = 1'b0; operand = 64'hF0; shamt = 6'd4; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        nvec++;
        if ({busy, result} !== {1'b1, 64'h28}) begin
            nerr++;
            $display("FAIL b2b_hold: got busy=%b result=%h, want 1 28", busy, result);
        end
        lat = -1;
        for (int k = 0; k < 50; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        nvec++;
        if ({lat, result} !== {32'd5, 64'hF}) begin
            nerr++;
            $display("FAIL b2b_second: got lat=%0d result=%h, want 5 f", lat, result);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_shifts();
        test_word();
        test_zero_len();
        test_ignored_start();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
